vga_timing_sched: RTL and testbench
===================================

// Module: vga_timing_sched
// PURPOSE
//  640x480@60 VGA timing controller and pattern scheduler. Divides the system clock to a pixel enable.
//  Generates hc/vc, hsync/vsync and vidon for the pattern generators (stripes etc.).
//  Selects one of NPAT generator outputs as the 3-3-2 RGB drive, switching only at frame boundaries.
// PARAMETERS
//  CLK_DIV        4    system clocks per pixel (100 MHz -> 25 MHz); >=1
//  HPIXELS        800  pixels per line (hc wraps at HPIXELS-1)
//  VLINES         521  lines per frame (vc wraps at VLINES-1)
//  HSYNC_W        96   hsync low while hc < HSYNC_W
//  VSYNC_W        2    vsync low while vc < VSYNC_W
//  HBP / HFP      144 / 784  visible when HBP <= hc < HFP
//  VBP / VFP      31 / 511   visible when VBP <= vc < VFP
//  NPAT           4    pattern inputs; power of two, >=2
//  FRAMES_PER_PAT 60   frames per pattern in AUTO mode; >=1
// PORTS
//  clk       in   1        system clock
//  clr       in   1        async reset, active-high
//  pat_next  in   1        1-clk pulse: request advance to next pattern and enter HOLD mode
//  pat_auto  in   1        1-clk pulse: request return to AUTO mode
//  pat_rgb   in   8*NPAT   generator k colour at [8k+7:8k] = {red[2:0],green[2:0],blue[1:0]}
//  hc, vc    out  10 each  pixel/line counters (registered)
//  hsync     out  1        active-low horizontal sync
//  vsync     out  1        active-low vertical sync
//  vidon     out  1        visible-area flag
//  red       out  3        colour out; 0 when vidon=0
//  green     out  3        colour out; 0 when vidon=0
//  blue      out  2        colour out; 0 when vidon=0
//  pat_idx   out  log2(NPAT)  active pattern index (registered)
//  frame_start out 1       1-clk pulse on the clock where hc/vc wrap to 0/0
// BEHAVIOUR
//  Reset: div=0, hc=0, vc=0, pat_idx=0, frame_cnt=0, next_pend=0, auto_pend=0, state=AUTO.
//   Consequently hsync=0, vsync=0, vidon=0, rgb=0, frame_start=0 during/after reset.
//  Pixel enable: div counts 0..CLK_DIV-1; pe=1 when div==CLK_DIV-1; first pe on CLK_DIV-th edge after clr drop.
//  On pe: hc+1; at hc==HPIXELS-1, hc->0 and vc+1; at vc==VLINES-1 also, vc->0. No change without pe.
//  hsync/vsync/vidon: combinational decode of registered hc/vc, per parameter ranges.
//  RGB: combinational mux of pat_rgb[pat_idx] gated by vidon; zero latency relative to hc/vc.
//  frame_start = pe & hc==HPIXELS-1 & vc==VLINES-1 (the boundary cycle).
//  Requests: pat_next sets next_pend, pat_auto sets auto_pend; pulses held until boundary, then cleared.
//   Pulse arriving on the boundary cycle itself is applied at the NEXT boundary.
//  Scheduler FSM, evaluated only at frame_start:
//   AUTO: next_pend -> idx+1, frame_cnt=0, ->HOLD. Else frame_cnt==FRAMES_PER_PAT-1 -> idx+1, frame_cnt=0;
//         else frame_cnt+1. auto_pend in AUTO: no effect (cleared).
//   HOLD: next_pend & auto_pend -> idx+1, frame_cnt=0, ->AUTO. next_pend -> idx+1, stay HOLD.
//         auto_pend -> frame_cnt=0, ->AUTO. Neither: no change; frame_cnt frozen.
//  pat_idx wraps NPAT-1 -> 0 (natural modulo). frame_cnt width ceil(log2(FRAMES_PER_PAT)) min 1.
//  pat_idx never changes mid-frame: no tearing.
//  clr mid-frame: immediate return to reset values; pending requests discarded.
// CONFIGURATION
//  BORDER_EN defined: when vidon and (hc==HBP | hc==HFP-1 | vc==VBP | vc==VFP-1), rgb=8'hFF overriding pattern.
//  BORDER_EN undefined: rgb strictly pattern mux gated by vidon; no border logic synthesised.
// TESTING
//  Counters: release clr; hc=1 after 4 clks, hc 799->0 with vc 0->1 at clk 3200; frame = 1,667,200 clks.
//  Sync/vidon: hsync=0 for hc 0..95, 1 at 96; vsync=0 for vc 0..1; vidon=1 only hc 144..783 & vc 31..510.
//  AUTO (FRAMES_PER_PAT=2): pat_idx 0,0,1,1,2,2,3,3,0 across 9 frames; frame_start once per frame.
//  HOLD: pat_next at vc=200 in frame 0 -> idx stays 0 until frame_start, then 1; idx=1 for next 5 frames.
//  Both: in HOLD, pat_next & pat_auto same clk -> at boundary idx+1, AUTO; idx+1 again 60 frames later.
//  clr at hc=400,vc=300 -> hc=vc=0, idx=0, rgb=0; with BORDER_EN hc=144,vc=200 pattern 8'h12 -> rgb=8'hFF.

Source files
------------

// File: rtl/vga_timing_sched.sv
// -----------------------------------------------------------------------------
// vga_timing_sched
//
// Purpose:
//    VGA timing controller (640x480@60 with the default parameters) combined
//    with a pattern scheduler. A clock divider produces a one-cycle pixel
//    enable. Registered pixel/line counters are decoded into sync, visible-area
//    and colour outputs. The colour comes from one of NPAT pattern generator
//    inputs, and the selection changes only at frame boundaries.
//
//    Scheduler modes:
//       AUTO - advance to the next pattern every FRAMES_PER_PAT frames.
//       HOLD - keep the current pattern until the user asks for another.
//    pat_next and pat_auto pulses are latched until the next frame boundary.
//    A pulse that arrives on the boundary cycle itself takes effect at the
//    following boundary.
//
// Build option:
//    BORDER_EN - when defined, draws a white (8'hFF) one-pixel frame on the
//                first and last visible column and row, over the pattern.
//                When undefined, no border logic is present.
//
// Ports:
//    clk          in   system clock
//    clr          in   asynchronous reset, active-high
//    pat_next     in   1-clk pulse: advance the pattern and enter HOLD
//    pat_auto     in   1-clk pulse: return to AUTO
//    pat_rgb      in   8*NPAT packed colours, generator k at [8k+7:8k],
//                      each {red[2:0],green[2:0],blue[1:0]}
//    hc, vc       out  pixel and line counters (registered)
//    hsync        out  active-low horizontal sync
//    vsync        out  active-low vertical sync
//    vidon        out  visible-area flag
//    red/green/blue out 3-3-2 colour, forced to zero outside the visible area
//    pat_idx      out  active pattern index (registered)
//    frame_start  out  1-clk pulse on the cycle where hc/vc wrap to 0/0
// -----------------------------------------------------------------------------
module vga_timing_sched #(
   parameter int CLK_DIV        = 4,
   parameter int HPIXELS        = 800,
   parameter int VLINES         = 521,
   parameter int HSYNC_W        = 96,
   parameter int VSYNC_W        = 2,
   parameter int HBP            = 144,
   parameter int HFP            = 784,
   parameter int VBP            = 31,
   parameter int VFP            = 511,
   parameter int NPAT           = 4,
   parameter int FRAMES_PER_PAT = 60
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic                    pat_next,
   input  logic                    pat_auto,
   input  logic [8*NPAT-1:0]       pat_rgb,
   output logic [9:0]              hc,
   output logic [9:0]              vc,
   output logic                    hsync,
   output logic                    vsync,
   output logic                    vidon,
   output logic [2:0]              red,
   output logic [2:0]              green,
   output logic [1:0]              blue,
   output logic [$clog2(NPAT)-1:0] pat_idx,
   output logic                    frame_start
);

   localparam int PW = $clog2(NPAT);
   localparam int FW = (FRAMES_PER_PAT > 1) ? $clog2(FRAMES_PER_PAT) : 1;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
   localparam logic [FW-1:0] FC_MAX  = FW'(FRAMES_PER_PAT - 1);
   localparam logic [9:0]    H_MAX   = 10'(HPIXELS - 1);
   localparam logic [9:0]    V_MAX   = 10'(VLINES - 1);
   localparam logic [9:0]    HS_END  = 10'(HSYNC_W);
   localparam logic [9:0]    VS_END  = 10'(VSYNC_W);
   localparam logic [9:0]    H_VIS0  = 10'(HBP);
   localparam logic [9:0]    H_VIS1  = 10'(HFP);
   localparam logic [9:0]    V_VIS0  = 10'(VBP);
   localparam logic [9:0]    V_VIS1  = 10'(VFP);
`ifdef BORDER_EN
   localparam logic [9:0]    H_LAST  = 10'(HFP - 1);
   localparam logic [9:0]    V_LAST  = 10'(VFP - 1);
`endif

   typedef enum logic {
      ST_AUTO = 1'b0,
      ST_HOLD = 1'b1
   } sched_state_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [DW-1:0] div_q,       div_d;
   logic [9:0]    hc_q,        hc_d;
   logic [9:0]    vc_q,        vc_d;
   logic [PW-1:0] idx_q,       idx_d;
   logic [FW-1:0] fc_q,        fc_d;
   logic          next_pend_q, next_pend_d;
   logic          auto_pend_q, auto_pend_d;
   sched_state_e  state_q,     state_d;

   logic          pe;
   logic [7:0]    pat_arr [NPAT];
   logic [7:0]    rgb_pat;
   logic [7:0]    rgb;

   // NOTE: sequential state is updated only with non-blocking assignments, so
   // every register samples the values from before the edge and the order of
   // statements inside this block does not matter.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         div_q       <= '0;
         hc_q        <= '0;
         vc_q        <= '0;
         idx_q       <= '0;
         fc_q        <= '0;
         next_pend_q <= 1'b0;
         auto_pend_q <= 1'b0;
         state_q     <= ST_AUTO;
      end else begin
         div_q       <= div_d;
         hc_q        <= hc_d;
         vc_q        <= vc_d;
         idx_q       <= idx_d;
         fc_q        <= fc_d;
         next_pend_q <= next_pend_d;
         auto_pend_q <= auto_pend_d;
         state_q     <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Pixel enable and raster counters
   // ---------------------------------------------------------------------------
   assign pe = (div_q == DIV_MAX);

   // NOTE: every signal written in an always_comb gets a default value first.
   // Then no path through the if/case tree can leave it unassigned, and no
   // latch is inferred.
   always_comb begin
      div_d = pe ? '0 : div_q + DW'(1);
      hc_d  = hc_q;
      vc_d  = vc_q;
      if (pe) begin
         if (hc_q == H_MAX) begin
            hc_d = '0;
            vc_d = (vc_q == V_MAX) ? '0 : vc_q + 10'd1;
         end else begin
            hc_d = hc_q + 10'd1;
         end
      end
   end

   // The last pixel clock of the frame is the one and only place where the
   // scheduler is allowed to act.
   assign frame_start = pe && (hc_q == H_MAX) && (vc_q == V_MAX);

   // ---------------------------------------------------------------------------
   // Request latches: a pulse is held until the next boundary. On the boundary
   // cycle the old value is consumed, and a pulse arriving on that same cycle
   // starts the new pending value.
   // ---------------------------------------------------------------------------
   always_comb begin
      next_pend_d = frame_start ? pat_next : (next_pend_q | pat_next);
      auto_pend_d = frame_start ? pat_auto : (auto_pend_q | pat_auto);
   end

   // ---------------------------------------------------------------------------
   // Scheduler FSM, evaluated only on frame_start
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      fc_d    = fc_q;
      if (frame_start) begin
         case (state_q)
            ST_AUTO: begin
               // A pending auto request has no effect in AUTO. It is dropped
               // along with the latch.
               if (next_pend_q) begin
                  idx_d   = idx_q + PW'(1);
                  fc_d    = '0;
                  state_d = ST_HOLD;
               end else if (fc_q == FC_MAX) begin
                  idx_d = idx_q + PW'(1);
                  fc_d  = '0;
               end else begin
                  fc_d = fc_q + FW'(1);
               end
            end
            ST_HOLD: begin
               // The frame counter stays frozen while holding. Leaving HOLD
               // restarts the dwell count.
               if (next_pend_q) begin
                  idx_d = idx_q + PW'(1);
               end
               if (auto_pend_q) begin
                  fc_d    = '0;
                  state_d = ST_AUTO;
               end
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Sync / visible-area decode of the registered counters
   // ---------------------------------------------------------------------------
   assign hsync = (hc_q >= HS_END);
   assign vsync = (vc_q >= VS_END);
   assign vidon = (hc_q >= H_VIS0) && (hc_q < H_VIS1) &&
                  (vc_q >= V_VIS0) && (vc_q < V_VIS1);

   // ---------------------------------------------------------------------------
   // Colour path: zero-latency mux of the selected generator
   // ---------------------------------------------------------------------------
   always_comb begin
      for (int k = 0; k < NPAT; k++) begin
         pat_arr[k] = pat_rgb[8*k +: 8];
      end
   end

   assign rgb_pat = pat_arr[idx_q];

`ifdef BORDER_EN
   logic border;

   assign border = (hc_q == H_VIS0) || (hc_q == H_LAST) ||
                   (vc_q == V_VIS0) || (vc_q == V_LAST);

   always_comb begin
      rgb = 8'h00;
      if (vidon) begin
         rgb = border ? 8'hFF : rgb_pat;
      end
   end
`else
   assign rgb = vidon ? rgb_pat : 8'h00;
`endif

   assign red     = rgb[7:5];
   assign green   = rgb[4:2];
   assign blue    = rgb[1:0];
   assign hc      = hc_q;
   assign vc      = vc_q;
   assign pat_idx = idx_q;

endmodule

// File: tb/tb_vga_timing_sched.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_sched
//
// Self-checking bench for vga_timing_sched. The raster is shrunk so that many
// frames fit in a short run.
//
// Stimulus side: drives random pattern colours and request pulses. It keeps a
// frame-level reference of the scheduler rules and pushes the expected pattern
// index of each new frame into a scoreboard queue.
//
// Monitor side: samples on the falling edge. It derives the expected raster
// position from the number of clock edges since reset, checks timing and colour
// every cycle, and pops the scoreboard whenever the DUT raises frame_start.
// -----------------------------------------------------------------------------
module tb_vga_timing_sched;

   localparam int CLK_DIV = 2;
   localparam int HP      = 20;
   localparam int VL      = 12;
   localparam int HS_W    = 3;
   localparam int VS_W    = 2;
   localparam int HBP     = 5;
   localparam int HFP     = 17;
   localparam int VBP     = 3;
   localparam int VFP     = 10;
   localparam int NPAT    = 4;
   localparam int FPP     = 3;
   localparam int PW      = $clog2(NPAT);
   localparam int FCLK    = CLK_DIV * HP * VL;   // clocks per frame

   logic                clk = 1'b0;
   logic                clr;
   logic                pat_next;
   logic                pat_auto;
   logic [8*NPAT-1:0]   pat_rgb;
   logic [9:0]          hc;
   logic [9:0]          vc;
   logic                hsync;
   logic                vsync;
   logic                vidon;
   logic [2:0]          red;
   logic [2:0]          green;
   logic [1:0]          blue;
   logic [PW-1:0]       pat_idx;
   logic                frame_start;

   vga_timing_sched #(
      .CLK_DIV        (CLK_DIV),
      .HPIXELS        (HP),
      .VLINES         (VL),
      .HSYNC_W        (HS_W),
      .VSYNC_W        (VS_W),
      .HBP            (HBP),
      .HFP            (HFP),
      .VBP            (VBP),
      .VFP            (VFP),
      .NPAT           (NPAT),
      .FRAMES_PER_PAT (FPP)
   ) dut (
      .clk         (clk),
      .clr         (clr),
      .pat_next    (pat_next),
      .pat_auto    (pat_auto),
      .pat_rgb     (pat_rgb),
      .hc          (hc),
      .vc          (vc),
      .hsync       (hsync),
      .vsync       (vsync),
      .vidon       (vidon),
      .red         (red),
      .green       (green),
      .blue        (blue),
      .pat_idx     (pat_idx),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int q_exp[$];          // expected pattern index for each upcoming frame

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Clock edges seen since reset was released. Reset holds it at zero.
   int n_edge;
   always @(posedge clk or posedge clr) begin
      if (clr) n_edge <= 0;
      else     n_edge <= n_edge + 1;
   end

   // ---------------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------------
   int cur_idx = 0;
   int nxt_idx = 0;
   bit idx_pend = 1'b0;

   always @(negedge clk) begin : monitor
      int         p;
      int         ehc;
      int         evc;
      bit         e_vid;
      bit         e_fs;
      logic [7:0] e_rgb;
      if (clr) begin
         cur_idx  = 0;
         idx_pend = 1'b0;
         check("reset_hc_vc", 32'({hc, vc}), 32'd0);
         check("reset_outputs", 32'({hsync, vsync, vidon, red, green, blue, frame_start, pat_idx}), 32'd0);
      end else begin
         p     = n_edge / CLK_DIV;
         ehc   = p % HP;
         evc   = (p / HP) % VL;
         e_vid = (ehc >= HBP) && (ehc < HFP) && (evc >= VBP) && (evc < VFP);
         e_fs  = ((n_edge + 1) % FCLK) == 0;

         // The index popped at the last frame_start becomes visible one cycle later.
         if (idx_pend) begin
            cur_idx  = nxt_idx;
            idx_pend = 1'b0;
         end

         e_rgb = e_vid ? pat_rgb[8*cur_idx +: 8] : 8'h00;
`ifdef BORDER_EN
         if (e_vid && (ehc == HBP || ehc == HFP - 1 || evc == VBP || evc == VFP - 1)) begin
            e_rgb = 8'hFF;
         end
`endif
         check("hc", 32'(hc), 32'(ehc));
         check("vc", 32'(vc), 32'(evc));
         check("hsync", 32'(hsync), 32'(ehc >= HS_W));
         check("vsync", 32'(vsync), 32'(evc >= VS_W));
         check("vidon", 32'(vidon), 32'(e_vid));
         check("rgb", 32'({red, green, blue}), 32'(e_rgb));
         check("pat_idx", 32'(pat_idx), 32'(cur_idx));
         check("frame_start", 32'(frame_start), 32'(e_fs));

         if (frame_start) begin
            if (q_exp.size() == 0) begin
               check("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
               nxt_idx  = q_exp.pop_front();
               idx_pend = 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus and frame-level reference model
   // ---------------------------------------------------------------------------
   int mcyc;               // cycles since reset release
   bit m_hold;             // 0 = AUTO, 1 = HOLD
   int m_idx;
   int m_fc;               // frames already shown in AUTO for this pattern
   bit m_np;
   bit m_ap;

   task automatic model_reset();
      mcyc   = 0;
      m_hold = 1'b0;
      m_idx  = 0;
      m_fc   = 0;
      m_np   = 1'b0;
      m_ap   = 1'b0;
   endtask

   // Drive one cycle, then advance to just after the next rising edge.
   task automatic step(input bit nx, input bit au);
      pat_next = nx;
      pat_auto = au;
      for (int k = 0; k < NPAT; k++) pat_rgb[8*k +: 8] = 8'($urandom);
      if (((mcyc + 1) % FCLK) == 0) begin
         if (m_hold) begin
            if (m_np) m_idx = (m_idx + 1) % NPAT;
            if (m_ap) begin
               m_hold = 1'b0;
               m_fc   = 0;
            end
         end else if (m_np) begin
            m_idx  = (m_idx + 1) % NPAT;
            m_fc   = 0;
            m_hold = 1'b1;
         end else if (m_fc == FPP - 1) begin
            m_idx = (m_idx + 1) % NPAT;
            m_fc  = 0;
         end else begin
            m_fc = m_fc + 1;
         end
         q_exp.push_back(m_idx);
         m_np = nx;
         m_ap = au;
      end else begin
         m_np = m_np | nx;
         m_ap = m_ap | au;
      end
      @(posedge clk);
      #1;
      mcyc++;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0);
   endtask

   task automatic to_offset(input int off);
      while ((mcyc % FCLK) != off) step(1'b0, 1'b0);
   endtask

   // Random pulses at pm per-mille per cycle. Boundary cycles get a much higher
   // rate so the "late pulse" corner case shows up often.
   task automatic random_run(input int n, input int pm);
      bit bnd;
      bit nx;
      bit au;
      repeat (n) begin
         bnd = ((mcyc + 1) % FCLK) == 0;
         nx  = bnd ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 999) < pm);
         au  = bnd ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 999) < pm);
         step(nx, au);
      end
   endtask

   initial begin
      clr      = 1'b1;
      pat_next = 1'b0;
      pat_auto = 1'b0;
      pat_rgb  = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      clr = 1'b0;
      model_reset();

      // AUTO rotation with no requests.
      idle(10 * FCLK);

      // pat_next mid-frame: index changes at the boundary, then HOLD freezes it.
      to_offset(6 * HP * CLK_DIV + 4);
      step(1'b1, 1'b0);
      idle(5 * FCLK);

      // Both requests on the same cycle while in HOLD.
      to_offset(FCLK / 2);
      step(1'b1, 1'b1);
      idle(4 * FCLK);

      // pat_auto while already in AUTO.
      to_offset(100);
      step(1'b0, 1'b1);
      idle(2 * FCLK);

      // Pulse on the boundary cycle itself: deferred by one frame.
      to_offset(FCLK - 1);
      step(1'b1, 1'b0);
      idle(2 * FCLK);

      random_run(20 * FCLK, 3);

      // Reset in the middle of a frame discards everything.
      to_offset(7 * HP * CLK_DIV + 9);
      check("scoreboard_before_clr", 32'(q_exp.size()), 32'd0);
      clr = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      clr = 1'b0;
      model_reset();
      q_exp.delete();

      random_run(6 * FCLK, 3);
      idle(3);
      check("scoreboard_drain", 32'(q_exp.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
